// File: rtl/register_pkg.sv
// -----------------------------------------------------------------------------
// register_pkg
// Shared constants and types for the byte-enabled register.
//   DEFAULT_WIDTH : default data width in bits (32)
//   DEFAULT_LANES : number of 8-bit byte lanes at the default width
//   data_t        : data word of the default width
// No ports; imported by the register top and by its byte-lane flop.
// -----------------------------------------------------------------------------
package register_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_LANES = DEFAULT_WIDTH / 8;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : register_pkg

// File: rtl/register_byte_lane.sv
// -----------------------------------------------------------------------------
// register_byte_lane
// One 8-bit storage lane of the register: a bank of flops with asynchronous
// active-high reset and a lane-level write enable.
// Ports:
//   clk  in   1  rising-edge clock
//   rst  in   1  asynchronous active-high reset, loads RESET_VALUE
//   en   in   1  lane write enable (already qualified by the byte enable)
//   d    in   8  lane data
//   q    out  8  registered lane data
// -----------------------------------------------------------------------------
module register_byte_lane
    import register_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // Lane storage: reset dominates, otherwise load only when enabled so the
    // lane holds its value whenever it is not being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : register_byte_lane

// File: rtl/register.sv
// -----------------------------------------------------------------------------
// register
// WIDTH-bit register with per-byte write enables and asynchronous reset.
// q comes straight from flops; there is no combinational path from any input.
// WIDTH must be a positive multiple of 8.
// Ports:
//   d    in   WIDTH    data to capture
//   clk  in   1        rising-edge clock
//   q    out  WIDTH    registered data
//   rst  in   1        asynchronous active-high reset, q <= RESET_VALUE
//   en   in   1        write enable for the next rising edge
//   be   in   WIDTH/8  byte enables, bit i gates bits 8i+7..8i
//   par  out  1        even parity (^q), present only with REGISTER_PARITY_EN
// Configuration macro: REGISTER_PARITY_EN adds the registered parity output.
// -----------------------------------------------------------------------------
module register
    import register_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0]   d,
    input  logic               clk,
    output logic [WIDTH-1:0]   q,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH/8-1:0] be
`ifdef REGISTER_PARITY_EN
    ,
    output logic               par
`endif
);

    localparam int LANES = WIDTH / 8;

    logic [LANES-1:0] lane_en;

    // A lane is written only when the global enable and its byte enable agree.
    assign lane_en = be & {LANES{en}};

    // One independent 8-bit flop bank per byte lane.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        register_byte_lane #(
            .RESET_VALUE (RESET_VALUE[8*i +: 8])
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (lane_en[i]),
            .d   (d[8*i +: 8]),
            .q   (q[8*i +: 8])
        );
    end

`ifdef REGISTER_PARITY_EN
    logic [WIDTH-1:0] q_next;

    // Value q will hold after the coming edge; parity is taken from this so
    // that par updates on the same edge as q and always matches ^q.
    always_comb begin
        q_next = q;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                q_next[8*i +: 8] = d[8*i +: 8];
            end
        end
    end

    // Parity flop, reset to the parity of the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= ^RESET_VALUE;
        end else begin
            par <= ^q_next;
        end
    end
`endif

endmodule : register

// File: tb/tb_register.sv
// -----------------------------------------------------------------------------
// tb_register
// Self-checking bench for register at the default 32-bit width.
// Build with REGISTER_PARITY_EN defined to also exercise the par output.
// -----------------------------------------------------------------------------
module tb_register;
    import register_pkg::*;

    typedef struct {
        string                    name;
        logic                     en;
        logic [DEFAULT_LANES-1:0] be;
        data_t                    d;
        data_t                    exp_q;
    } vec_t;

    data_t                    d;
    logic                     clk;
    data_t                    q;
    logic                     rst;
    logic                     en;
    logic [DEFAULT_LANES-1:0] be;
`ifdef REGISTER_PARITY_EN
    logic                     par;
`endif

    int passed;
    int total;

    vec_t vecs[13];

    register dut (
        .d   (d),
        .clk (clk),
        .q   (q),
        .rst (rst),
        .en  (en),
        .be  (be)
`ifdef REGISTER_PARITY_EN
        ,
        .par (par)
`endif
    );

    // One full clock period: rising edge mid-way, ends with clk low so that
    // checks happen well away from the active edge.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    // Drive the synchronous inputs while the clock is low.
    task automatic applyStimulus(input logic e, input logic [DEFAULT_LANES-1:0] b,
                                 input data_t dv);
        en = e;
        be = b;
        d  = dv;
    endtask

    // Compare q (and par, if present) against the expected word.
    task automatic checkOutput(input string name, input data_t exp_q);
        total++;
        if (q === exp_q) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: q=%08h expected %08h", name, q, exp_q);
        end
`ifdef REGISTER_PARITY_EN
        total++;
        if (par === ^exp_q) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s_par: par=%0b expected %0b", name, par, ^exp_q);
        end
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;

        vecs[0]  = '{"load_zero",    1'b1, 4'hF, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{"load_ones",    1'b1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2]  = '{"load_0f",      1'b1, 4'hF, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
        vecs[3]  = '{"hold_1",       1'b0, 4'hF, 32'h1234_5678, 32'h0F0F_0F0F};
        vecs[4]  = '{"hold_2",       1'b0, 4'hF, 32'h1234_5678, 32'h0F0F_0F0F};
        vecs[5]  = '{"hold_3",       1'b0, 4'hF, 32'h1234_5678, 32'h0F0F_0F0F};
        vecs[6]  = '{"reload_ones",  1'b1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7]  = '{"be_0011",      1'b1, 4'h3, 32'hAABB_CCDD, 32'hFFFF_CCDD};
        vecs[8]  = '{"be_0100",      1'b1, 4'h4, 32'h1122_3344, 32'hFF22_CCDD};
        vecs[9]  = '{"be_none",      1'b1, 4'h0, 32'h0000_0000, 32'hFF22_CCDD};
        vecs[10] = '{"be_1000",      1'b1, 4'h8, 32'h1200_0000, 32'h1222_CCDD};
        vecs[11] = '{"en_off_be_on", 1'b0, 4'hF, 32'h0000_0000, 32'h1222_CCDD};
        vecs[12] = '{"load_1234",    1'b1, 4'hF, 32'h1234_5678, 32'h1234_5678};

        clk = 1'b0;
        rst = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0);
        #3;

        // Reset with the clock idle must act immediately.
        d   = 32'hFFFF_FFFF;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", 32'h0000_0000);

        // Clock edges are ignored while reset is held, even with a write pending.
        applyStimulus(1'b1, 4'hF, 32'hFFFF_FFFF);
        tick();
        tick();
        checkOutput("reset_hold", 32'h0000_0000);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].en, vecs[i].be, vecs[i].d);
            tick();
            checkOutput(vecs[i].name, vecs[i].exp_q);
        end

        // Changing inputs between edges must not reach q.
        applyStimulus(1'b1, 4'hF, 32'hDEAD_BEEF);
        #2;
        d = 32'h0BAD_F00D;
        #2;
        checkOutput("no_comb_path", 32'h1234_5678);
        d = 32'h1234_5678;

        // Reset mid-operation, between edges, with a write held pending.
        rst = 1'b1;
        #1;
        checkOutput("reset_mid", 32'h0000_0000);
        applyStimulus(1'b1, 4'hF, 32'hCAFE_F00D);
        tick();
        checkOutput("reset_mid_edge1", 32'h0000_0000);
        tick();
        checkOutput("reset_mid_edge2", 32'h0000_0000);
        rst = 1'b0;
        #1;
        checkOutput("reset_release", 32'h0000_0000);
        tick();
        checkOutput("first_write", 32'hCAFE_F00D);

        // Reset asserted at the same instant as a write edge wins.
        applyStimulus(1'b1, 4'hF, 32'h5555_AAAA);
        #5;
        rst = 1'b1;
        clk = 1'b1;
        #5 clk = 1'b0;
        checkOutput("reset_beats_write", 32'h0000_0000);
        rst = 1'b0;
        #1;

        // Parity corner values (q checks also run without the parity build).
        applyStimulus(1'b1, 4'hF, 32'h0000_0001);
        tick();
        checkOutput("par_one", 32'h0000_0001);
        applyStimulus(1'b1, 4'hF, 32'h0000_0003);
        tick();
        checkOutput("par_three", 32'h0000_0003);
        applyStimulus(1'b1, 4'h2, 32'h0000_0100);
        tick();
        checkOutput("par_lane1", 32'h0000_0103);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_register
